pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, rst.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: data-memory wait cycles before the timeout flag is set.
REQ-003 Parameter CNT_W, default 16: width of the performance counters.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- Rs1D, Rs2D  in  5  decode-stage source registers
- BranchD  in  1  decode holds a conditional branch
- PCSrcD  in  1  branch taken, resolved in decode
- JalD  in  1  jump in decode
- Rs1E, Rs2E, RdE  in  5  execute-stage registers
- RegWriteEnE, MemReadEnE  in  1  execute-stage controls
- RdM  in  5  memory-stage destination
- RegWriteEnM, MemReadEnM, MemWriteEnM  in  1  memory-stage controls
- RdW  in  5  writeback-stage destination
- RegWriteEnW  in  1  writeback-stage write enable
- dmem_ready  in  1  data memory completes access this cycle
- StallF, StallD, StallE, StallM  out  1  hold the PC and the D/E/M pipeline registers
- FlushD, FlushE, FlushW  out  1  load a bubble into the D/E/W pipeline registers
- ForwardAE, ForwardBE  out  2  ALU operand select: 00 register file, 01 writeback, 10 memory
- mem_timeout  out  1  sticky memory-timeout error
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

Function
REQ-005 FSM SHALL have two states: RUN and MEM_WAIT; the state SHALL be registered on the rising edge of clk.
REQ-006 memreq SHALL be defined as MemReadEnM | MemWriteEnM.
REQ-007 RUN -> MEM_WAIT when memreq=1 and dmem_ready=0; MEM_WAIT -> RUN on the cycle dmem_ready=1; otherwise the state holds.
REQ-008 Memory wait SHALL be active when memreq=1 and dmem_ready=0, in either state. Required response: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
REQ-009 Load-use hazard SHALL be detected as MemReadEnE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).
REQ-010 Branch-compare hazard SHALL be detected as BranchD & RdE!=0 & (RdE==Rs1D | RdE==Rs2D) & RegWriteEnE, or as BranchD & MemReadEnM & RdM!=0 & (RdM==Rs1D | RdM==Rs2D).
REQ-011 Either hazard from REQ-009/REQ-010, with no memory wait, SHALL assert StallF=StallD=1 and FlushE=1 for that cycle only. FlushD=0 in that cycle.
REQ-012 Redirect: PCSrcD | JalD, with no memory wait and no hazard from REQ-009/REQ-010, SHALL assert FlushD=1.
REQ-013 Priority SHALL be: memory wait > data/branch hazard > redirect.
REQ-014 With no condition from REQ-008 to REQ-012 active, all stall and flush outputs SHALL be 0.
REQ-015 ForwardAE SHALL be:
- 10 when RegWriteEnM & RdM!=0 & RdM==Rs1E;
- else 01 when RegWriteEnW & RdW!=0 & RdW==Rs1E;
- else 00.
REQ-016 ForwardBE SHALL follow the REQ-015 rule using Rs2E; the memory-stage match SHALL win over the writeback match.
REQ-017 Stall, flush and forward outputs SHALL be combinational from the current inputs and FSM state; they SHALL have no added latency.
REQ-018 Wait counter: a TIMEOUT-width counter SHALL increment each cycle in MEM_WAIT and clear on entry to RUN.
REQ-019 When the wait counter reaches TIMEOUT_CYCLES-1 while still waiting, mem_timeout SHALL be set and SHALL remain 1 until rst.
REQ-020 The pipeline SHALL remain stalled after a timeout.
REQ-021 stall_cnt SHALL increment by 1 on every cycle with StallF=1; flush_cnt SHALL increment by 1 on every cycle with FlushD|FlushE=1.
REQ-022 Both counters SHALL saturate at 2^CNT_W-1 and SHALL not wrap.
REQ-023 Register x0 SHALL never cause a hazard or a forward.

Reset
REQ-024 While rst=1, outputs SHALL be: Stall*=0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00.
REQ-025 On the clock edge with rst=1, the next state SHALL be: FSM=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
REQ-026 rst asserted during MEM_WAIT SHALL return the FSM to RUN on the next edge, regardless of dmem_ready.

Verification
REQ-027 Load-use: MemReadEnE=1, RdE=5, Rs1D=5 for one cycle -> StallF=StallD=FlushE=1 for exactly one cycle; stall_cnt=1.
REQ-028 Forwarding: RegWriteEnM=1, RdM=3; RegWriteEnW=1, RdW=3; Rs1E=3, Rs2E=3 -> ForwardAE=ForwardBE=10. With RdM=0 -> ForwardAE=ForwardBE=01.
REQ-029 Memory wait: MemReadEnM=1, dmem_ready=0 for 3 cycles then 1 -> all four stalls and FlushW=1 for 3 cycles; state=RUN after the ready cycle; stall_cnt=3.
REQ-030 Simultaneous events: load-use hazard plus PCSrcD=1 -> FlushD=0, FlushE=1. Then the same with dmem_ready=0 and MemWriteEnM=1 -> only the memory-wait response.
REQ-031 Timeout: TIMEOUT_CYCLES=16, dmem_ready held 0 with memreq=1 -> mem_timeout=1 after the 16th wait cycle; it stays 1 after dmem_ready=1 and clears only on rst.
REQ-032 Saturation and reset: CNT_W=4 with 20 stall cycles -> stall_cnt=15. rst during MEM_WAIT -> RUN and all counters=0 next cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a five-stage in-order pipeline.
// Produces the stall, flush and forward controls from the current pipeline
// contents, and tracks data-memory waits with a timeout flag and two
// saturating event counters.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Rs1D/Rs2D, BranchD,      decode-stage sources, branch and redirect info
//   PCSrcD, JalD
//   Rs1E/Rs2E/RdE, RegWriteEnE, MemReadEnE            execute stage
//   RdM, RegWriteEnM, MemReadEnM, MemWriteEnM          memory stage
//   RdW, RegWriteEnW                                    writeback stage
//   dmem_ready               data memory completes its access this cycle
//   StallF/D/E/M             hold the PC and the D/E/M pipeline registers
//   FlushD/E/W               load a bubble into D/E/W
//   ForwardAE/BE             00 regfile, 01 writeback, 10 memory
//   mem_timeout              sticky memory-timeout error
//   stall_cnt, flush_cnt     saturating event counters

// Forward select for one ALU operand; memory stage beats writeback.
module hazard_fwd_sel (
  input  logic [4:0] rs,
  input  logic [4:0] rd_m,
  input  logic       we_m,
  input  logic [4:0] rd_w,
  input  logic       we_w,
  output logic [1:0] sel
);
  always_comb begin
    sel = 2'b00;
    if (we_m && rd_m != 5'd0 && rd_m == rs)      sel = 2'b10;
    else if (we_w && rd_w != 5'd0 && rd_w == rs) sel = 2'b01;
  end
endmodule

module pipeline_hazard_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             JalD,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             RegWriteEnE,
  input  logic             MemReadEnE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteEnM,
  input  logic             MemReadEnM,
  input  logic             MemWriteEnM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteEnW,
  input  logic             dmem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_LANES = 2;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]    WAIT_MAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    WAIT_HIT = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [TW-1:0]    WAIT_ONE = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t        state;
  logic [TW-1:0] wait_cnt;

  logic memreq, mem_wait, load_use, br_haz, hazard;
  logic d1_match_e, d1_match_m;

  assign memreq   = MemReadEnM | MemWriteEnM;
  assign mem_wait = memreq & ~dmem_ready;

  assign d1_match_e = (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
  assign d1_match_m = (RdM != 5'd0) && (RdM == Rs1D || RdM == Rs2D);
  assign load_use   = MemReadEnE & d1_match_e;
  // Branches compare in decode, so an ALU result still in E or a load in M
  // is not yet available to the comparator.
  assign br_haz     = BranchD & ((RegWriteEnE & d1_match_e) | (MemReadEnM & d1_match_m));
  assign hazard     = load_use | br_haz;

  // Forwarding, one lane per ALU operand (lane 0 = A, lane 1 = B).
  logic [NUM_LANES-1:0][4:0] rs_e;
  logic [NUM_LANES-1:0][1:0] fwd;
  assign rs_e = {Rs2E, Rs1E};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_fwd
      hazard_fwd_sel u_sel (
        .rs   (rs_e[g]),
        .rd_m (RdM),
        .we_m (RegWriteEnM),
        .rd_w (RdW),
        .we_w (RegWriteEnW),
        .sel  (fwd[g])
      );
    end
  endgenerate

  // Priority: reset > memory wait > data/branch hazard > redirect.
  // A timeout does not release the stall; the pipeline keeps waiting on memory.
  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0;
    ForwardAE = fwd[0];
    ForwardBE = fwd[1];
    if (rst) begin
      FlushD = 1'b1; FlushE = 1'b1; FlushW = 1'b1;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
    end else if (mem_wait) begin
      StallF = 1'b1; StallD = 1'b1; StallE = 1'b1; StallM = 1'b1;
      FlushW = 1'b1;
    end else if (hazard) begin
      StallF = 1'b1; StallD = 1'b1;
      FlushE = 1'b1;
    end else if (PCSrcD | JalD) begin
      FlushD = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      if (StallF && stall_cnt != '1)             stall_cnt <= stall_cnt + CNT_ONE;
      if ((FlushD | FlushE) && flush_cnt != '1)  flush_cnt <= flush_cnt + CNT_ONE;
      case (state)
        RUN: begin
          wait_cnt <= '0;
          if (mem_wait) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_ONE;
            // Flag on the edge where the count reaches TIMEOUT_CYCLES-1.
            if (memreq && wait_cnt >= WAIT_HIT) mem_timeout <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: a table of single-cycle vectors with
// hand-computed controls, hand sequences for the multi-cycle corners, and a
// randomized run scored against a behavioural model of the rules.
module tb_pipeline_hazard_controller;
  localparam int TMO = 16;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1d, rs2d;
    logic       br, pcsrc, jal;
    logic [4:0] rs1e, rs2e, rde;
    logic       rwe_e, mre_e;
    logic [4:0] rdm;
    logic       rwe_m, mre_m, mwe_m;
    logic [4:0] rdw;
    logic       rwe_w, ready;
  } in_t;

  // {SF,SD,SE,SM,FD,FE,FW,FAE[1:0],FBE[1:0]}
  typedef struct {
    in_t         i;
    logic [10:0] e;
    string       nm;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t cur;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_timeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_controller #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(cur.rst),
    .Rs1D(cur.rs1d), .Rs2D(cur.rs2d), .BranchD(cur.br), .PCSrcD(cur.pcsrc), .JalD(cur.jal),
    .Rs1E(cur.rs1e), .Rs2E(cur.rs2e), .RdE(cur.rde), .RegWriteEnE(cur.rwe_e), .MemReadEnE(cur.mre_e),
    .RdM(cur.rdm), .RegWriteEnM(cur.rwe_m), .MemReadEnM(cur.mre_m), .MemWriteEnM(cur.mwe_m),
    .RdW(cur.rdw), .RegWriteEnW(cur.rwe_w), .dmem_ready(cur.ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  wire [10:0] dut_comb = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE};

  int checks = 0;
  int failures = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // ---------------- behavioural model ----------------
  bit m_wait;
  int m_wc, m_sc, m_fc;
  bit m_tmo;

  function automatic logic [1:0] m_fw(logic [4:0] rs, in_t x);
    if (x.rwe_m && x.rdm != 0 && x.rdm == rs) return 2'b10;
    if (x.rwe_w && x.rdw != 0 && x.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_memwait(in_t x);
    return (x.mre_m || x.mwe_m) && !x.ready;
  endfunction

  function automatic logic [10:0] m_comb(in_t x);
    bit lu, bh, use_e, use_m;
    logic [3:0] f;
    if (x.rst) return 11'b0000_111_00_00;
    use_e = x.rde != 0 && (x.rde == x.rs1d || x.rde == x.rs2d);
    use_m = x.rdm != 0 && (x.rdm == x.rs1d || x.rdm == x.rs2d);
    lu = x.mre_e && use_e;
    bh = x.br && ((x.rwe_e && use_e) || (x.mre_m && use_m));
    f = {m_fw(x.rs1e, x), m_fw(x.rs2e, x)};
    if (m_memwait(x))       return {7'b1111_001, f};
    if (lu || bh)           return {7'b1100_010, f};
    if (x.pcsrc || x.jal)   return {7'b0000_100, f};
    return {7'b0, f};
  endfunction

  function automatic void m_step(in_t x);
    logic [10:0] e;
    if (x.rst) begin
      m_wait = 0; m_wc = 0; m_tmo = 0; m_sc = 0; m_fc = 0;
      return;
    end
    e = m_comb(x);
    if (e[10])          m_sc = (m_sc < SAT) ? m_sc + 1 : SAT;
    if (e[6] || e[5])   m_fc = (m_fc < SAT) ? m_fc + 1 : SAT;
    if (!m_wait) begin
      if (m_memwait(x)) m_wait = 1;
    end else if (x.ready) begin
      m_wait = 0; m_wc = 0;
    end else begin
      m_wc++;
      if (m_memwait(x) && m_wc >= TMO - 1) m_tmo = 1;
    end
  endfunction

  // Check the current cycle against the model (called at the negedge),
  // then advance through the rising edge.
  task automatic finish_cycle(string nm);
    chk({nm, "/ctl"}, 32'(dut_comb), 32'(m_comb(cur)));
    chk({nm, "/tmo"}, 32'(mem_timeout), 32'(m_tmo));
    chk({nm, "/scnt"}, 32'(stall_cnt), 32'(m_sc));
    chk({nm, "/fcnt"}, 32'(flush_cnt), 32'(m_fc));
    @(posedge clk);
    m_step(cur);
    #1;
  endtask

  task automatic tick(string nm);
    @(negedge clk);
    finish_cycle(nm);
  endtask

  in_t idle;
  rec_t tbl[$];

  task automatic add(in_t i, logic [10:0] e, string nm);
    rec_t r;
    r.i = i; r.e = e; r.nm = nm;
    tbl.push_back(r);
  endtask

  task automatic do_reset();
    cur = idle; cur.rst = 1'b1;
    tick("rst"); tick("rst");
    cur = idle;
  endtask

  initial begin
    in_t t;
    idle = '0; idle.ready = 1'b1;

    // -------- vector table --------
    t = idle;                                                add(t, 11'b0000_000_00_00, "idle");
    t = idle; t.mre_e = 1; t.rde = 5; t.rs1d = 5;            add(t, 11'b1100_010_00_00, "lu_rs1");
    t = idle; t.mre_e = 1; t.rde = 7; t.rs2d = 7;            add(t, 11'b1100_010_00_00, "lu_rs2");
    t = idle; t.mre_e = 1; t.rde = 0; t.rs1d = 0;            add(t, 11'b0000_000_00_00, "lu_x0");
    t = idle; t.br = 1; t.rwe_e = 1; t.rde = 4; t.rs1d = 4;  add(t, 11'b1100_010_00_00, "br_e");
    t = idle; t.br = 1; t.mre_m = 1; t.rdm = 6; t.rs2d = 6;  add(t, 11'b1100_010_00_00, "br_m");
    t = idle; t.rwe_e = 1; t.rde = 4; t.rs1d = 4;            add(t, 11'b0000_000_00_00, "nobr");
    t = idle; t.pcsrc = 1;                                   add(t, 11'b0000_100_00_00, "pcsrc");
    t = idle; t.jal = 1;                                     add(t, 11'b0000_100_00_00, "jal");
    t = idle; t.mre_e = 1; t.rde = 5; t.rs1d = 5; t.pcsrc = 1; add(t, 11'b1100_010_00_00, "lu_pcsrc");
    t = idle; t.rwe_m = 1; t.rdm = 3; t.rwe_w = 1; t.rdw = 3; t.rs1e = 3; t.rs2e = 3;
                                                             add(t, 11'b0000_000_10_10, "fw_mem");
    t.rdm = 0;                                               add(t, 11'b0000_000_01_01, "fw_wb");
    t = idle; t.rwe_w = 1; t.rdw = 9; t.rs2e = 9; t.rs1e = 2; add(t, 11'b0000_000_00_01, "fw_b_only");
    t = idle; t.rdm = 3; t.rs1e = 3;                         add(t, 11'b0000_000_00_00, "fw_nowe");
    t = idle; t.mre_e = 1; t.rde = 5; t.rs1d = 5; t.pcsrc = 1; t.mwe_m = 1; t.ready = 0;
                                                             add(t, 11'b1111_001_00_00, "mw_prio");

    m_step('{rst: 1'b1, default: '0});
    do_reset();
    chk("reset_scnt", 32'(stall_cnt), 0);
    chk("reset_tmo", 32'(mem_timeout), 0);

    foreach (tbl[k]) begin
      cur = tbl[k].i;
      @(negedge clk);
      chk(tbl[k].nm, 32'(dut_comb), 32'(tbl[k].e));
      finish_cycle(tbl[k].nm);
    end

    // -------- load-use: one stall cycle --------
    do_reset();
    cur.mre_e = 1; cur.rde = 5; cur.rs1d = 5;
    tick("lu1");
    cur = idle; tick("lu1_after");
    chk("lu1_cnt", 32'(stall_cnt), 1);

    // -------- memory wait for 3 cycles --------
    do_reset();
    cur.mre_m = 1; cur.ready = 0;
    repeat (3) tick("mw3");
    cur.ready = 1; tick("mw3_ready");
    cur = idle; tick("mw3_idle");
    chk("mw3_cnt", 32'(stall_cnt), 3);

    // -------- rst during MEM_WAIT, then timeout --------
    do_reset();
    cur.mre_m = 1; cur.ready = 0;
    repeat (3) tick("pre_wait");
    cur.rst = 1; tick("rst_in_wait");
    chk("rst_wait_scnt", 32'(stall_cnt), 0);
    chk("rst_wait_fcnt", 32'(flush_cnt), 0);
    cur.rst = 0;
    repeat (TMO - 1) tick("tmo_wait");
    chk("tmo_early", 32'(mem_timeout), 0);
    tick("tmo_wait16");
    chk("tmo_set", 32'(mem_timeout), 1);
    cur.ready = 1; tick("tmo_ready");
    cur = idle; repeat (2) tick("tmo_idle");
    chk("tmo_sticky", 32'(mem_timeout), 1);
    do_reset();
    chk("tmo_cleared", 32'(mem_timeout), 0);

    // -------- counter saturation --------
    cur.mre_e = 1; cur.rde = 5; cur.rs1d = 5;
    repeat (20) tick("sat");
    chk("sat_scnt", 32'(stall_cnt), SAT);
    chk("sat_fcnt", 32'(flush_cnt), SAT);

    // -------- randomized run --------
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cur.rst   = ($urandom_range(0, 49) == 0);
      cur.rs1d  = 5'($urandom_range(0, 3)); cur.rs2d = 5'($urandom_range(0, 3));
      cur.br    = 1'($urandom_range(0, 1)); cur.pcsrc = ($urandom_range(0, 3) == 0);
      cur.jal   = ($urandom_range(0, 5) == 0);
      cur.rs1e  = 5'($urandom_range(0, 3)); cur.rs2e = 5'($urandom_range(0, 3));
      cur.rde   = 5'($urandom_range(0, 3));
      cur.rwe_e = 1'($urandom_range(0, 1)); cur.mre_e = ($urandom_range(0, 2) == 0);
      cur.rdm   = 5'($urandom_range(0, 3));
      cur.rwe_m = 1'($urandom_range(0, 1)); cur.mre_m = ($urandom_range(0, 2) == 0);
      cur.mwe_m = ($urandom_range(0, 3) == 0);
      cur.rdw   = 5'($urandom_range(0, 3)); cur.rwe_w = 1'($urandom_range(0, 1));
      cur.ready = (n % 100 > 60 && n % 100 < 85) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
